parity_sreg_edit: RTL and testbench
===================================

Name: parity_sreg_edit

Overview:
Parametrised successor to the A12 parity/S-register tray. It holds the memory address (S) register and decodes S into central-register and editing-register selects. It generates and checks odd parity on memory words through a registered pipeline, with a sticky alarm and an error counter, and performs the CYR/SR/CYL/EDOP edit transforms on words written to the editing addresses. It sits between the write bus and the memory/G-register interface.

Parameters:
DATA_W, 15, data bits per word; parity occupies bit DATA_W of the word bus.
ADDR_W, 12, S register width.
CENTRAL_TOP, 7, addresses 0..CENTRAL_TOP are central registers and are exempt from parity checking.
EDIT_BASE, 16, address of CYR; SR, CYL and EDOP are EDIT_BASE+1..+3.
EDOP_SH, 7, right shift applied by EDOP.
CNT_W, 4, width of the parity error counter.

Ports:
CLOCK  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset.
WL  in  DATA_W  write bus, active-high in this block.
WSG  in  1  load S from WL[ADDR_W-1:0].
WG  in  1  write strobe for word WL into the edit unit.
GWORD  in  DATA_W+1  word read from memory; MSB is the parity bit.
GEN  in  1  request parity generation on WL.
CHK  in  1  request parity check on GWORD.
PALE_CLR  in  1  clear alarm.
S  out  ADDR_W  address register.
GEQZRO_  out  1  low when S==0.
CENTRAL  out  1  S<=CENTRAL_TOP.
CYR_, SR_, CYL_, EDOP_  out  1 each  active-low editing-address decodes.
PGEN  out  1  generated parity bit.
PVALID  out  1  one-cycle pulse; PGEN is valid.
PALE  out  1  sticky parity alarm.
PERR_CNT  out  CNT_W  saturating parity error count.
EDIT_Q  out  DATA_W  edited word.
EDIT_VALID  out  1  one-cycle pulse; EDIT_Q is valid.

Behaviour:
- Reset (rst low, asynchronous):
  - S=0, PGEN=0, PVALID=0, PALE=0, PERR_CNT=0, EDIT_Q=0, EDIT_VALID=0.
  - Decodes follow from S=0: GEQZRO_=0, CENTRAL=1, CYR_/SR_/CYL_/EDOP_ all 1.
  - Reset mid-operation discards any in-flight GEN, CHK or WG.
- S register:
  - On WSG, S<=WL[ADDR_W-1:0] at the clock edge.
  - Decodes are combinational from the registered S.
  - Any bits of WL above ADDR_W are ignored.
- Parity generation:
  - GEN at edge n gives PGEN=~^WL (odd parity over DATA_W bits) and PVALID=1 at edge n+1.
  - PVALID deasserts the following cycle unless GEN is held.
  - Back-to-back GEN gives one result per cycle.
- Parity check:
  - CHK at edge n evaluates ^GWORD using the S value present at edge n.
  - Even total parity with CENTRAL=0 is an error, registered at edge n+1: PALE<=1 and PERR_CNT increments.
  - CENTRAL=1 suppresses the check.
  - PERR_CNT saturates at 2^CNT_W-1.
  - PALE_CLR clears PALE only; PERR_CNT clears only on reset.
  - An error and PALE_CLR in the same cycle leave PALE=1 (the error wins).
- Edit unit:
  - WG at edge n with S==EDIT_BASE+k gives EDIT_Q at edge n+1, with EDIT_VALID=1.
  - CYR (k=0): rotate right by 1.
  - SR (k=1): arithmetic shift right by 1; MSB replicated.
  - CYL (k=2): rotate left by 1.
  - EDOP (k=3): logical right shift by EDOP_SH, zero-filled.
  - WG to any other address: EDIT_VALID=0 and EDIT_Q holds its value.
- WSG and WG in the same cycle:
  - The edit uses the old S.
  - The new S applies from the next cycle.
- Widths: all edit operations are performed on DATA_W bits; the parity bit never enters the edit unit.

Test Plan:
- Reset checks: rst low mid-GEN -> all outputs at reset values, PVALID=0 next cycle, GEQZRO_=0, CENTRAL=1.
- Generate and check:
  - GEN, WL=15'o00001 -> PGEN=0, PVALID pulse at +1.
  - WL=15'o00003 -> PGEN=1.
  - Back-to-back GENs -> consecutive PVALID pulses.
- Check errors:
  - WSG WL=12'o2000, then CHK GWORD=16'h0003 -> PALE=1, PERR_CNT=1.
  - S=5 with the same GWORD -> no alarm.
  - Error coincident with PALE_CLR -> PALE stays 1.
- Saturation: 20 consecutive error CHKs -> PERR_CNT=15 and stays 15; PALE_CLR leaves PERR_CNT=15.
- Edit transforms, each checked one cycle after WG:
  - S=o20, WL=15'o00001 -> EDIT_Q=15'o40000.
  - S=o21, WL=15'o40002 -> 15'o60001.
  - S=o22, WL=15'o40000 -> 15'o00001.
  - S=o23, WL=15'o77777 -> 15'o00377.
- Same-cycle WSG to o21 and WG with S=o20 -> CYR applied; SR_=0 on the following cycle; WG to o24 -> EDIT_VALID=0.

Source files
------------

// File: rtl/parity_sreg_edit.sv
// S (address) register with central/editing decodes, odd-parity generate/check
// pipeline with sticky alarm and saturating error count, and the CYR/SR/CYL/EDOP edit unit.
module parity_sreg_edit #(
  parameter int DATA_W      = 15,
  parameter int ADDR_W      = 12,
  parameter int CENTRAL_TOP = 7,
  parameter int EDIT_BASE   = 16,
  parameter int EDOP_SH     = 7,
  parameter int CNT_W       = 4
) (
  input  logic              CLOCK,
  input  logic              rst,
  input  logic [DATA_W-1:0] WL,
  input  logic              WSG,
  input  logic              WG,
  input  logic [DATA_W:0]   GWORD,
  input  logic              GEN,
  input  logic              CHK,
  input  logic              PALE_CLR,
  output logic [ADDR_W-1:0] S,
  output logic              GEQZRO_,
  output logic              CENTRAL,
  output logic              CYR_,
  output logic              SR_,
  output logic              CYL_,
  output logic              EDOP_,
  output logic              PGEN,
  output logic              PVALID,
  output logic              PALE,
  output logic [CNT_W-1:0]  PERR_CNT,
  output logic [DATA_W-1:0] EDIT_Q,
  output logic              EDIT_VALID
);

  localparam int NUM_EDIT = 4;

  logic [ADDR_W-1:0] r_s;
  logic              r_pgen;
  logic              r_pvalid;
  logic              r_pale;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_edit_q;
  logic              r_edit_valid;

  logic [NUM_EDIT-1:0] w_edit_sel;
  logic                w_central;
  logic                w_err;
  logic                w_edit_hit;
  logic [DATA_W-1:0]   w_edit_word;

  // One select per editing address, decoded from the registered S.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_EDIT; gi++) begin : g_edit_dec
      assign w_edit_sel[gi] = (r_s == ADDR_W'(EDIT_BASE + gi));
    end
  endgenerate

  assign w_central  = (r_s <= ADDR_W'(CENTRAL_TOP));
  assign w_edit_hit = |w_edit_sel;
  // Even total parity on a non-central word is the only error condition.
  assign w_err      = CHK && !w_central && !(^GWORD);

  always_comb begin
    w_edit_word = r_edit_q;
    if (w_edit_sel[0])
      w_edit_word = {WL[0], WL[DATA_W-1:1]};
    else if (w_edit_sel[1])
      w_edit_word = {WL[DATA_W-1], WL[DATA_W-1:1]};
    else if (w_edit_sel[2])
      w_edit_word = {WL[DATA_W-2:0], WL[DATA_W-1]};
    else if (w_edit_sel[3])
      w_edit_word = WL >> EDOP_SH;
  end

  always_ff @(posedge CLOCK or negedge rst) begin
    if (!rst) begin
      r_s          <= '0;
      r_pgen       <= 1'b0;
      r_pvalid     <= 1'b0;
      r_pale       <= 1'b0;
      r_cnt        <= '0;
      r_edit_q     <= '0;
      r_edit_valid <= 1'b0;
    end else begin
      if (WSG)
        r_s <= WL[ADDR_W-1:0];

      r_pvalid <= GEN;
      if (GEN)
        r_pgen <= ~^WL;

      // The error term is tested first so it wins over a simultaneous clear.
      if (w_err)
        r_pale <= 1'b1;
      else if (PALE_CLR)
        r_pale <= 1'b0;

      if (w_err && (r_cnt != {CNT_W{1'b1}}))
        r_cnt <= r_cnt + 1'b1;

      r_edit_valid <= WG && w_edit_hit;
      if (WG && w_edit_hit)
        r_edit_q <= w_edit_word;
    end
  end

  assign S          = r_s;
  assign GEQZRO_    = |r_s;
  assign CENTRAL    = w_central;
  assign CYR_       = ~w_edit_sel[0];
  assign SR_        = ~w_edit_sel[1];
  assign CYL_       = ~w_edit_sel[2];
  assign EDOP_      = ~w_edit_sel[3];
  assign PGEN       = r_pgen;
  assign PVALID     = r_pvalid;
  assign PALE       = r_pale;
  assign PERR_CNT   = r_cnt;
  assign EDIT_Q     = r_edit_q;
  assign EDIT_VALID = r_edit_valid;

endmodule

// File: tb/tb_parity_sreg_edit.sv
// Bench for parity_sreg_edit: directed scenarios plus randomized traffic
// compared against an arithmetic reference model of the block's behaviour.
module tb_parity_sreg_edit;

  logic        CLOCK = 1'b0;
  logic        rst;
  logic [14:0] WL;
  logic        WSG, WG, GEN, CHK, PALE_CLR;
  logic [15:0] GWORD;
  logic [11:0] S;
  logic        GEQZRO_, CENTRAL, CYR_, SR_, CYL_, EDOP_;
  logic        PGEN, PVALID, PALE, EDIT_VALID;
  logic [3:0]  PERR_CNT;
  logic [14:0] EDIT_Q;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int m_s, m_cnt, m_editq;
  bit m_pgen, m_pvalid, m_pale, m_editv;

  parity_sreg_edit dut (
    .CLOCK(CLOCK), .rst(rst), .WL(WL), .WSG(WSG), .WG(WG), .GWORD(GWORD),
    .GEN(GEN), .CHK(CHK), .PALE_CLR(PALE_CLR), .S(S), .GEQZRO_(GEQZRO_),
    .CENTRAL(CENTRAL), .CYR_(CYR_), .SR_(SR_), .CYL_(CYL_), .EDOP_(EDOP_),
    .PGEN(PGEN), .PVALID(PVALID), .PALE(PALE), .PERR_CNT(PERR_CNT),
    .EDIT_Q(EDIT_Q), .EDIT_VALID(EDIT_VALID)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic drive(input bit wsg, input bit wg, input bit gen, input bit chk,
                       input bit clr, input int wl, input int gw);
    WSG = wsg; WG = wg; GEN = gen; CHK = chk; PALE_CLR = clr;
    WL = 15'(wl); GWORD = 16'(gw);
  endtask

  task automatic model_reset();
    m_s = 0; m_cnt = 0; m_editq = 0;
    m_pgen = 0; m_pvalid = 0; m_pale = 0; m_editv = 0;
  endtask

  // Advance the model by one clock from the current inputs, then clock the DUT.
  task automatic cycle();
    int x, k;
    bit err;
    x = int'(WL);
    if (GEN) m_pgen = ($countones(WL) % 2 == 0);
    m_pvalid = GEN;
    err = CHK && (m_s > 7) && ($countones(GWORD) % 2 == 0);
    if (err) begin
      m_pale = 1;
      if (m_cnt < 15) m_cnt = m_cnt + 1;
    end else if (PALE_CLR) m_pale = 0;
    k = m_s - 16;
    m_editv = WG && k >= 0 && k <= 3;
    if (m_editv) begin
      case (k)
        0: m_editq = (x / 2) + (x % 2) * 16384;
        1: m_editq = (x / 2) + ((x >= 16384) ? 16384 : 0);
        2: m_editq = ((x * 2) % 32768) + x / 16384;
        default: m_editq = x / 128;
      endcase
    end
    if (WSG) m_s = x % 4096;
    @(posedge CLOCK);
    #1;
  endtask

  task automatic apply_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    model_reset();
    @(posedge CLOCK);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge CLOCK);
    #1;
    n_vec++;
    if ({S, PGEN, PVALID, PALE, PERR_CNT, EDIT_Q, EDIT_VALID} !== '0) begin
      n_err++; $display("FAIL reset_regs: got S=%0h PGEN=%0b PVALID=%0b PALE=%0b CNT=%0d EDIT_Q=%0h EV=%0b, want all 0",
                        S, PGEN, PVALID, PALE, PERR_CNT, EDIT_Q, EDIT_VALID);
    end
    n_vec++;
    if ({GEQZRO_, CENTRAL, CYR_, SR_, CYL_, EDOP_} !== 6'b011111) begin
      n_err++; $display("FAIL reset_decodes: got %b, want 011111", {GEQZRO_, CENTRAL, CYR_, SR_, CYL_, EDOP_});
    end
    rst = 1'b1;
    // put S somewhere non-trivial, then start a GEN and reset mid-flight
    drive(1, 0, 0, 0, 0, 'o21, 0); cycle();
    drive(0, 0, 1, 0, 0, 'o3, 0);  cycle();
    n_vec++;
    if (PVALID !== 1'b1) begin
      n_err++; $display("FAIL reset_pre_gen: PVALID got %b want 1", PVALID);
    end
    #2 rst = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if ({S, PVALID, PGEN, GEQZRO_, CENTRAL, SR_} !== {12'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
      n_err++; $display("FAIL reset_async: S=%0h PVALID=%b PGEN=%b GEQZRO_=%b CENTRAL=%b SR_=%b, want S=0 0 0 0 1 1",
                        S, PVALID, PGEN, GEQZRO_, CENTRAL, SR_);
    end
    @(posedge CLOCK);
    #1;
    n_vec++;
    if (PVALID !== 1'b0) begin
      n_err++; $display("FAIL reset_next: PVALID got %b want 0", PVALID);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
  endtask

  task automatic test_gen();
    drive(0, 0, 1, 0, 0, 'o1, 0); cycle();
    n_vec++;
    if (PGEN !== 1'b0 || PVALID !== 1'b1) begin
      n_err++; $display("FAIL gen_o1: PGEN=%b PVALID=%b, want 0 1", PGEN, PVALID);
    end
    drive(0, 0, 1, 0, 0, 'o3, 0); cycle();
    n_vec++;
    if (PGEN !== 1'b1 || PVALID !== 1'b1) begin
      n_err++; $display("FAIL gen_o3: PGEN=%b PVALID=%b, want 1 1", PGEN, PVALID);
    end
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 1, 0, 0, int'($urandom_range(0, 32767)), 0); cycle();
      n_vec++;
      if (PGEN !== m_pgen || PVALID !== 1'b1) begin
        n_err++; $display("FAIL gen_b2b[%0d]: PGEN=%b PVALID=%b, want %b 1", i, PGEN, PVALID, m_pgen);
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0); cycle();
    n_vec++;
    if (PVALID !== 1'b0) begin
      n_err++; $display("FAIL gen_drop: PVALID=%b want 0", PVALID);
    end
  endtask

  task automatic test_check();
    drive(1, 0, 0, 0, 0, 'o2000, 0); cycle();
    drive(0, 0, 0, 1, 0, 0, 'h0003); cycle();
    n_vec++;
    if (PALE !== 1'b1 || PERR_CNT !== 4'd1) begin
      n_err++; $display("FAIL chk_err: PALE=%b CNT=%0d, want 1 1", PALE, PERR_CNT);
    end
    drive(0, 0, 0, 0, 1, 0, 0); cycle();
    n_vec++;
    if (PALE !== 1'b0 || PERR_CNT !== 4'd1) begin
      n_err++; $display("FAIL chk_clr: PALE=%b CNT=%0d, want 0 1", PALE, PERR_CNT);
    end
    drive(1, 0, 0, 0, 0, 5, 0); cycle();
    drive(0, 0, 0, 1, 0, 0, 'h0003); cycle();
    n_vec++;
    if (PALE !== 1'b0 || PERR_CNT !== 4'd1) begin
      n_err++; $display("FAIL chk_central: PALE=%b CNT=%0d, want 0 1", PALE, PERR_CNT);
    end
    drive(1, 0, 0, 0, 0, 'o2000, 0); cycle();
    drive(0, 0, 0, 1, 1, 0, 'h0003); cycle();
    n_vec++;
    if (PALE !== 1'b1 || PERR_CNT !== 4'd2) begin
      n_err++; $display("FAIL chk_err_vs_clr: PALE=%b CNT=%0d, want 1 2", PALE, PERR_CNT);
    end
    drive(0, 0, 0, 1, 1, 0, 'h0007); cycle();
    n_vec++;
    if (PALE !== 1'b0 || PERR_CNT !== 4'd2) begin
      n_err++; $display("FAIL chk_odd_ok: PALE=%b CNT=%0d, want 0 2", PALE, PERR_CNT);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 0, 1, 0, 0, 'h0003); cycle();
    end
    n_vec++;
    if (PERR_CNT !== 4'd15 || PALE !== 1'b1) begin
      n_err++; $display("FAIL sat_cnt: CNT=%0d PALE=%b, want 15 1", PERR_CNT, PALE);
    end
    drive(0, 0, 0, 0, 1, 0, 0); cycle();
    n_vec++;
    if (PERR_CNT !== 4'd15 || PALE !== 1'b0) begin
      n_err++; $display("FAIL sat_clr: CNT=%0d PALE=%b, want 15 0", PERR_CNT, PALE);
    end
  endtask

  task automatic test_edit();
    int addr [4] = '{'o20, 'o21, 'o22, 'o23};
    int din  [4] = '{'o00001, 'o40002, 'o40000, 'o77777};
    int dout [4] = '{'o40000, 'o60001, 'o00001, 'o00377};
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0, 0, addr[i], 0); cycle();
      drive(0, 1, 0, 0, 0, din[i], 0);  cycle();
      n_vec++;
      if (EDIT_Q !== 15'(dout[i]) || EDIT_VALID !== 1'b1) begin
        n_err++; $display("FAIL edit_%0o: EDIT_Q=%0o EV=%b, want %0o 1", addr[i], EDIT_Q, EDIT_VALID, dout[i]);
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0); cycle();
    n_vec++;
    if (EDIT_VALID !== 1'b0 || EDIT_Q !== 15'o00377) begin
      n_err++; $display("FAIL edit_idle: EDIT_Q=%0o EV=%b, want 377 0", EDIT_Q, EDIT_VALID);
    end
  endtask

  task automatic test_same_cycle();
    drive(1, 0, 0, 0, 0, 'o20, 0); cycle();
    drive(1, 1, 0, 0, 0, 'o21, 0); cycle();
    n_vec++;
    if (EDIT_Q !== 15'o40010 || EDIT_VALID !== 1'b1) begin
      n_err++; $display("FAIL same_cyr: EDIT_Q=%0o EV=%b, want 40010 1", EDIT_Q, EDIT_VALID);
    end
    n_vec++;
    if (SR_ !== 1'b0 || CYR_ !== 1'b1 || S !== 12'o21) begin
      n_err++; $display("FAIL same_sdec: S=%0o SR_=%b CYR_=%b, want 21 0 1", S, SR_, CYR_);
    end
    drive(1, 0, 0, 0, 0, 'o24, 0);    cycle();
    drive(0, 1, 0, 0, 0, 'o12345, 0); cycle();
    n_vec++;
    if (EDIT_VALID !== 1'b0 || EDIT_Q !== 15'o40010) begin
      n_err++; $display("FAIL same_o24: EDIT_Q=%0o EV=%b, want 40010 0", EDIT_Q, EDIT_VALID);
    end
  endtask

  task automatic test_random();
    int wl;
    for (int i = 0; i < 300; i++) begin
      wl = int'($urandom_range(0, 32767));
      if ($urandom_range(0, 2) != 0)
        wl = (wl & 'h7000) | int'($urandom_range(0, 24));
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, wl, int'($urandom_range(0, 65535)));
      cycle();
      n_vec++;
      if (S !== 12'(m_s) || GEQZRO_ !== (m_s != 0) || CENTRAL !== (m_s <= 7) ||
          {CYR_, SR_, CYL_, EDOP_} !== {m_s != 16, m_s != 17, m_s != 18, m_s != 19}) begin
        n_err++; $display("FAIL rnd_s[%0d]: S=%0o dec=%b%b%b%b%b%b, want S=%0o", i, S, GEQZRO_, CENTRAL,
                          CYR_, SR_, CYL_, EDOP_, m_s);
      end
      n_vec++;
      if (PGEN !== m_pgen || PVALID !== m_pvalid) begin
        n_err++; $display("FAIL rnd_gen[%0d]: PGEN=%b PVALID=%b, want %b %b", i, PGEN, PVALID, m_pgen, m_pvalid);
      end
      n_vec++;
      if (PALE !== m_pale || PERR_CNT !== 4'(m_cnt)) begin
        n_err++; $display("FAIL rnd_chk[%0d]: PALE=%b CNT=%0d, want %b %0d", i, PALE, PERR_CNT, m_pale, m_cnt);
      end
      n_vec++;
      if (EDIT_Q !== 15'(m_editq) || EDIT_VALID !== m_editv) begin
        n_err++; $display("FAIL rnd_edit[%0d]: EDIT_Q=%0o EV=%b, want %0o %b", i, EDIT_Q, EDIT_VALID, m_editq, m_editv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_random();
    apply_reset();
    test_gen();
    test_check();
    test_saturation();
    test_edit();
    test_same_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
